mem_port_arbiter: RTL and testbench

Shares the miniRISC core's single-port unified memory between the instruction-fetch unit (IF) and the load/store unit (LS). Each cycle it grants at most one access using round-robin priority and drives the memory port. It tracks in-flight reads through a fixed-latency tag pipeline and steers each returning read word to the requester that issued it. It sits between the IF/LS stages and the BRAM wrapper.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_tag_pipe.sv | 28 ++
 rtl/mem_port_arbiter.sv | 99 +++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam int unsigned RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Fixed-depth shift register of read tags; cleared by synchronous reset.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t [RD_LAT-1:0] r_stage;
  tag_t [RD_LAT:0]   w_chain;

  // Input tag at the bottom, oldest stage at the top; depth-1 needs no special case.
  assign w_chain = {r_stage, i_tag};
  assign o_tag   = w_chain[RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage <= '0;
    end else begin
      r_stage <= w_chain[RD_LAT-1:0];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// steering each returning read word back to the requester that issued it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  owner_e r_last;
  logic   w_if_gnt;
  logic   w_ls_gnt;
  tag_t   w_tag_in;
  tag_t   w_tag_out;

  // On a tie the owner that did not win last time goes first.
  always_comb begin
    w_if_gnt = 1'b0;
    w_ls_gnt = 1'b0;
    if (!reset) begin
      if (if_req && ls_req) begin
        w_if_gnt = (r_last == OWN_LS);
        w_ls_gnt = (r_last == OWN_IF);
      end else begin
        w_if_gnt = if_req;
        w_ls_gnt = ls_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= OWN_LS;
    end else if (w_ls_gnt) begin
      r_last <= OWN_LS;
    end else if (w_if_gnt) begin
      r_last <= OWN_IF;
    end
  end

  assign if_gnt = w_if_gnt;
  assign ls_gnt = w_ls_gnt;
  assign mem_en = w_if_gnt | w_ls_gnt;
  assign mem_we = w_ls_gnt & ls_we;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_ls_gnt) begin
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (w_if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  always_comb begin
    w_tag_in.valid = mem_en & ~mem_we;
    w_tag_in.owner = w_ls_gnt ? OWN_LS : OWN_IF;
  end

  mem_arb_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  always_comb begin
    if_rvalid = w_tag_out.valid && (w_tag_out.owner == OWN_IF);
    ls_rvalid = w_tag_out.valid && (w_tag_out.owner == OWN_LS);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    ls_rdata  = ls_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RD_LAT=1 and RD_LAT=3 instances share one stimulus stream.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        mem_init;

  logic        d1_if_gnt, d1_if_rvalid, d1_ls_gnt, d1_ls_rvalid, d1_mem_en, d1_mem_we;
  logic [31:0] d1_if_rdata, d1_ls_rdata, d1_mem_addr, d1_mem_wdata, d1_mem_rdata;
  logic        d3_if_gnt, d3_if_rvalid, d3_ls_gnt, d3_ls_rvalid, d3_mem_en, d3_mem_we;
  logic [31:0] d3_if_rdata, d3_ls_rdata, d3_mem_addr, d3_mem_wdata, d3_mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(d1_if_gnt),
    .if_rvalid(d1_if_rvalid), .if_rdata(d1_if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(d1_ls_gnt), .ls_rvalid(d1_ls_rvalid), .ls_rdata(d1_ls_rdata),
    .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr),
    .mem_wdata(d1_mem_wdata), .mem_rdata(d1_mem_rdata)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(d3_if_gnt),
    .if_rvalid(d3_if_rvalid), .if_rdata(d3_if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(d3_ls_gnt), .ls_rvalid(d3_ls_rvalid), .ls_rdata(d3_ls_rdata),
    .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr),
    .mem_wdata(d3_mem_wdata), .mem_rdata(d3_mem_rdata)
  );

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {16'h0, a, 8'h00} ^ 32'h5A5A_0000;
  endfunction

  // Behavioural memories, one per DUT, each honouring its own read latency.
  logic [31:0]      st1 [256];
  logic [31:0]      st3 [256];
  logic [31:0]      p1;
  logic [2:0][31:0] p3;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        st1[i] <= init_word(8'(i));
        st3[i] <= init_word(8'(i));
      end
    end else begin
      if (d1_mem_en && d1_mem_we) st1[d1_mem_addr[7:0]] <= d1_mem_wdata;
      if (d3_mem_en && d3_mem_we) st3[d3_mem_addr[7:0]] <= d3_mem_wdata;
    end
    p1    <= (d1_mem_en && !d1_mem_we) ? st1[d1_mem_addr[7:0]] : $urandom;
    p3[0] <= (d3_mem_en && !d3_mem_we) ? st3[d3_mem_addr[7:0]] : $urandom;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign d1_mem_rdata = p1;
  assign d3_mem_rdata = p3[2];

  // Reference model: grant rule, word-addressed memory, queues of expected returns.
  typedef struct {
    int          due;
    logic        own;
    logic [31:0] d;
  } ret_t;

  ret_t        q1[$];
  ret_t        q3[$];
  logic [31:0] rm [256];
  logic        m_last;
  int          cyc;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
  endtask

  task automatic chk_port(input string p,
                          input logic ig, input logic lg, input logic en, input logic we,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input logic irv, input logic [31:0] ird,
                          input logic lrv, input logic [31:0] lrd,
                          input logic eig, input logic elg, input logic een, input logic ewe,
                          input logic [31:0] ead, input logic [31:0] ewd,
                          input logic ev, input ret_t er);
    logic ei, el;
    ei = ev && (er.own == 1'b0);
    el = ev && (er.own == 1'b1);
    chk({p, ".if_gnt"}, ig, eig);
    chk({p, ".ls_gnt"}, lg, elg);
    chk({p, ".mem_en"}, en, een);
    chk({p, ".mem_we"}, we, ewe);
    chk({p, ".mem_addr"}, ad, ead);
    chk({p, ".mem_wdata"}, wd, ewd);
    chk({p, ".if_rvalid"}, irv, ei);
    chk({p, ".if_rdata"}, ird, ei ? er.d : 32'h0);
    chk({p, ".ls_rvalid"}, lrv, el);
    chk({p, ".ls_rdata"}, lrd, el ? er.d : 32'h0);
  endtask

  task automatic step(input logic rst, input logic ifr, input logic [31:0] ifa,
                      input logic lsr, input logic lwe, input logic [31:0] lsa,
                      input logic [31:0] lwd, output logic g_if, output logic g_ls);
    logic        en, we, v1, v3;
    logic [31:0] ad, wd;
    ret_t        r1, r3;
    @(negedge clk);
    reset = rst; if_req = ifr; if_addr = ifa;
    ls_req = lsr; ls_we = lwe; ls_addr = lsa; ls_wdata = lwd;
    #1;
    if (rst) begin
      g_if = 1'b0; g_ls = 1'b0;
    end else if (ifr && lsr) begin
      g_if = m_last; g_ls = !m_last;
    end else begin
      g_if = ifr; g_ls = lsr;
    end
    en = g_if | g_ls;
    we = g_ls & lwe;
    ad = g_ls ? lsa : (g_if ? ifa : 32'h0);
    wd = g_ls ? lwd : 32'h0;
    r1 = '{0, 1'b0, 32'h0};
    r3 = '{0, 1'b0, 32'h0};
    v1 = (q1.size() != 0) && (q1[0].due == cyc);
    v3 = (q3.size() != 0) && (q3[0].due == cyc);
    if (v1) r1 = q1.pop_front();
    if (v3) r3 = q3.pop_front();
    chk_port("d1", d1_if_gnt, d1_ls_gnt, d1_mem_en, d1_mem_we, d1_mem_addr, d1_mem_wdata,
             d1_if_rvalid, d1_if_rdata, d1_ls_rvalid, d1_ls_rdata,
             g_if, g_ls, en, we, ad, wd, v1, r1);
    chk_port("d3", d3_if_gnt, d3_ls_gnt, d3_mem_en, d3_mem_we, d3_mem_addr, d3_mem_wdata,
             d3_if_rvalid, d3_if_rdata, d3_ls_rvalid, d3_ls_rdata,
             g_if, g_ls, en, we, ad, wd, v3, r3);
    if (rst) begin
      q1.delete(); q3.delete();
      m_last = 1'b1;
    end else if (en) begin
      m_last = g_ls;
      if (we) rm[ad[7:0]] = wd;
      else begin
        q1.push_back('{cyc + 1, g_ls, rm[ad[7:0]]});
        q3.push_back('{cyc + 3, g_ls, rm[ad[7:0]]});
      end
    end
    cyc++;
  endtask

  typedef struct {
    logic        rst, ifr;
    logic [31:0] ifa;
    logic        lsr, lwe;
    logic [31:0] lsa, lwd;
    logic        e_if, e_ls;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic rst, input logic ifr, input logic [31:0] ifa,
                              input logic lsr, input logic lwe, input logic [31:0] lsa,
                              input logic [31:0] lwd, input logic e_if, input logic e_ls);
    return '{rst, ifr, ifa, lsr, lwe, lsa, lwd, e_if, e_ls};
  endfunction

  initial begin
    logic        gi, gl;
    logic        pi, pl, pwe;
    logic [31:0] pa, pla, pwd;

    reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    mem_init = 1'b1;
    for (int i = 0; i < 256; i++) rm[i] = init_word(8'(i));
    q1.delete(); q3.delete();
    m_last = 1'b1;
    cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;

    vt.push_back(mk(1, 1, 32'h10, 1, 0, 32'h30, 32'h0,    0, 0));
    vt.push_back(mk(1, 1, 32'h10, 1, 0, 32'h30, 32'h0,    0, 0));
    vt.push_back(mk(0, 1, 32'h10, 0, 0, 32'h0,  32'h0,    1, 0));
    vt.push_back(mk(0, 0, 32'h0,  1, 1, 32'h20, 32'h1234, 0, 1));
    vt.push_back(mk(0, 1, 32'h20, 0, 0, 32'h0,  32'h0,    1, 0));
    vt.push_back(mk(0, 0, 32'h0,  1, 0, 32'h30, 32'h0,    0, 1));
    vt.push_back(mk(0, 1, 32'h11, 1, 0, 32'h31, 32'h0,    1, 0));
    vt.push_back(mk(0, 1, 32'h12, 1, 0, 32'h31, 32'h0,    0, 1));
    vt.push_back(mk(0, 1, 32'h12, 1, 0, 32'h32, 32'h0,    1, 0));
    vt.push_back(mk(0, 1, 32'h13, 1, 0, 32'h32, 32'h0,    0, 1));
    vt.push_back(mk(0, 1, 32'h13, 0, 0, 32'h0,  32'h0,    1, 0));
    vt.push_back(mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,    0, 0));
    vt.push_back(mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,    0, 0));
    vt.push_back(mk(0, 1, 32'h50, 1, 1, 32'h50, 32'hCAFE, 0, 1));
    vt.push_back(mk(0, 1, 32'h50, 0, 0, 32'h0,  32'h0,    1, 0));
    for (int i = 0; i < 3; i++) vt.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0));
    for (int i = 0; i < 3; i++) vt.push_back(mk(0, 1, 32'h60 + i, 0, 0, 32'h0, 32'h0, 1, 0));
    for (int i = 0; i < 3; i++) vt.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0));

    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].ifr, vt[i].ifa, vt[i].lsr, vt[i].lwe, vt[i].lsa, vt[i].lwd, gi, gl);
      chk($sformatf("vec%0d.if_gnt", i), d1_if_gnt, vt[i].e_if);
      chk($sformatf("vec%0d.ls_gnt", i), d1_ls_gnt, vt[i].e_ls);
    end

    // Reset one cycle after a read grant: the RD_LAT=3 return must never appear.
    step(0, 1, 32'h70, 0, 0, 32'h0, 32'h0, gi, gl);
    chk("midrst.grant", d3_if_gnt, 1'b1);
    step(1, 1, 32'h71, 1, 0, 32'h72, 32'h0, gi, gl);
    chk("midrst.if_gnt_in_reset", d3_if_gnt, 1'b0);
    chk("midrst.mem_en_in_reset", d3_mem_en, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, gi, gl);
      chk("midrst.no_if_rvalid", d3_if_rvalid, 1'b0);
      chk("midrst.no_ls_rvalid", d3_ls_rvalid, 1'b0);
    end
    step(0, 1, 32'h71, 1, 0, 32'h72, 32'h0, gi, gl);
    chk("midrst.tie_if", d3_if_gnt, 1'b1);
    chk("midrst.tie_ls", d3_ls_gnt, 1'b0);
    step(0, 0, 32'h0, 1, 0, 32'h72, 32'h0, gi, gl);
    chk("midrst.ls_next", d3_ls_gnt, 1'b1);

    // Randomized traffic with level-held requests over a small address window.
    pi = 1'b0; pl = 1'b0; pwe = 1'b0; pa = '0; pla = '0; pwd = '0;
    for (int n = 0; n < 400; n++) begin
      logic rst;
      if (!pi && ($urandom_range(0, 3) != 0)) begin
        pi = 1'b1; pa = 32'($urandom_range(0, 15));
      end
      if (!pl && ($urandom_range(0, 2) != 0)) begin
        pl = 1'b1; pla = 32'($urandom_range(0, 15));
        pwe = 1'($urandom_range(0, 1)); pwd = $urandom;
      end
      rst = ($urandom_range(0, 39) == 0);
      step(rst, pi, pi ? pa : 32'h0, pl, pl & pwe, pl ? pla : 32'h0, pl ? pwd : 32'h0, gi, gl);
      if (gi) pi = 1'b0;
      if (gl) pl = 1'b0;
    end
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, gi, gl);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
